// File: rtl/ifid_skid_fifo.sv
// IF/ID elastic buffer: DEPTH-entry circular FIFO with valid/ready on both sides and flush.
// Optional performance counters (stall_cnt, flush_cnt) are enabled by defining IFID_PERF_EN.
module ifid_skid_fifo #(
  parameter int DEPTH   = 2,
  parameter int INSTR_W = 32,
  parameter int ADDR_W  = 32,
  parameter int RSEL_W  = 5
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [INSTR_W-1:0]       in_instr,
  input  logic [ADDR_W-1:0]        in_jaddr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [INSTR_W-1:0]       out_instr,
  output logic [ADDR_W-1:0]        out_jaddr,
  output logic [RSEL_W-1:0]        out_rsel1,
  output logic [RSEL_W-1:0]        out_rsel2,
  output logic [$clog2(DEPTH):0]   count
`ifdef IFID_PERF_EN
  ,
  output logic [31:0]              stall_cnt,
  output logic [31:0]              flush_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [INSTR_W-1:0] r_instr_mem [DEPTH];
  logic [ADDR_W-1:0]  r_jaddr_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;

  logic w_in_ready;
  logic w_out_valid;
  logic w_push;
  logic w_pop;
  logic [INSTR_W-1:0] w_head_instr;

  // in_ready looks only at registered occupancy, so a full buffer never passes through
  assign w_in_ready  = (r_count < CNT_W'(DEPTH));
  assign w_out_valid = (r_count != {CNT_W{1'b0}});
  assign w_push      = in_valid & w_in_ready;
  assign w_pop       = w_out_valid & out_ready;

  assign w_head_instr = w_out_valid ? r_instr_mem[r_rd_ptr] : {INSTR_W{1'b0}};

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_instr = w_head_instr;
  assign out_jaddr = w_out_valid ? r_jaddr_mem[r_rd_ptr] : {ADDR_W{1'b0}};
  assign out_rsel1 = RSEL_W'(w_head_instr[25:21]);
  assign out_rsel2 = RSEL_W'(w_head_instr[20:16]);
  assign count     = r_count;

  // Flush outranks push and pop; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        r_instr_mem[i] <= {INSTR_W{1'b0}};
        r_jaddr_mem[i] <= {ADDR_W{1'b0}};
      end
    end else if (flush) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else begin
      if (w_push) begin
        r_instr_mem[r_wr_ptr] <= in_instr;
        r_jaddr_mem[r_wr_ptr] <= in_jaddr;
        r_wr_ptr              <= r_wr_ptr + PTR_W'(1);
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef IFID_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  // Saturating event counters for fetch back-pressure and pipeline flushes
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_stall_cnt <= 32'h0000_0000;
      r_flush_cnt <= 32'h0000_0000;
    end else begin
      if (in_valid && !w_in_ready && !flush && (r_stall_cnt != 32'hFFFF_FFFF)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end else begin
        r_stall_cnt <= r_stall_cnt;
      end
      if (flush && (r_flush_cnt != 32'hFFFF_FFFF)) begin
        r_flush_cnt <= r_flush_cnt + 32'd1;
      end else begin
        r_flush_cnt <= r_flush_cnt;
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_ifid_skid_fifo.sv
// Scoreboard bench for ifid_skid_fifo: directed scenarios followed by randomized traffic.
// The reference is a plain queue of accepted {jaddr, instr} pairs.
module tb_ifid_skid_fifo;
  localparam int DEPTH = 2;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = 32'h0;
  logic [31:0] in_jaddr = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_jaddr;
  logic [4:0]  out_rsel1;
  logic [4:0]  out_rsel2;
  logic [1:0]  count;
`ifdef IFID_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
  longint      m_stall = 0;
  longint      m_flush = 0;
`endif

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q [$];

  ifid_skid_fifo #(.DEPTH(DEPTH), .INSTR_W(32), .ADDR_W(32), .RSEL_W(5)) dut (
    .CLK(CLK), .nRST(nRST), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_jaddr(in_jaddr),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_jaddr(out_jaddr),
    .out_rsel1(out_rsel1), .out_rsel2(out_rsel2), .count(count)
`ifdef IFID_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare the presented head against the scoreboard, retire it when consumed
  always @(negedge CLK) begin
    logic [63:0] e;
    if (!nRST) begin
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_instr", 64'(out_instr), 64'd0);
      chk("rst_out_jaddr", 64'(out_jaddr), 64'd0);
      chk("rst_rsel", 64'({out_rsel1, out_rsel2}), 64'd0);
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
    end else begin
      chk("count", 64'(count), 64'(exp_q.size()));
      chk("in_ready", 64'(in_ready), 64'(exp_q.size() < DEPTH));
      chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        e = exp_q[0];
        chk("out_instr", 64'(out_instr), 64'(e[31:0]));
        chk("out_jaddr", 64'(out_jaddr), 64'(e[63:32]));
        chk("out_rsel1", 64'(out_rsel1), 64'(e[25:21]));
        chk("out_rsel2", 64'(out_rsel2), 64'(e[20:16]));
        if (out_ready && !flush) void'(exp_q.pop_front());
      end else begin
        chk("idle_instr", 64'(out_instr), 64'd0);
        chk("idle_jaddr", 64'(out_jaddr), 64'd0);
        chk("idle_rsel", 64'({out_rsel1, out_rsel2}), 64'd0);
      end
`ifdef IFID_PERF_EN
      chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
      chk("flush_cnt", 64'(flush_cnt), 64'(m_flush));
`endif
    end
  end

  // One cycle of stimulus; called at posedge+1, returns whether the model accepted the push
  task automatic cyc(input logic v, input logic [31:0] ins, input logic [31:0] ja,
                     input logic rdy, input logic fl, output logic acc);
    logic stall;
    in_valid = v; in_instr = ins; in_jaddr = ja; out_ready = rdy; flush = fl;
    acc   = v && !fl && (exp_q.size() < DEPTH);
    stall = v && !fl && (exp_q.size() >= DEPTH);
    @(posedge CLK);
    if (fl) exp_q.delete();
    else if (acc) exp_q.push_back({ja, ins});
`ifdef IFID_PERF_EN
    if (stall && m_stall < 64'hFFFF_FFFF) m_stall++;
    if (fl && m_flush < 64'hFFFF_FFFF) m_flush++;
`endif
    #1;
  endtask

  task automatic send(input logic [31:0] ins, input logic [31:0] ja, input logic rdy);
    logic acc;
    int n = 0;
    do begin
      cyc(1'b1, ins, ja, rdy, 1'b0, acc);
      n++;
    end while (!acc && n < 20);
    if (!acc) begin
      checks++; errors++;
      $display("FAIL send_timeout actual=not_accepted expected=accepted instr=%h", ins);
    end
  endtask

  task automatic idle(input logic rdy, input int n);
    logic acc;
    for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 32'h0, rdy, 1'b0, acc);
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    exp_q.delete();
`ifdef IFID_PERF_EN
    m_stall = 0; m_flush = 0;
`endif
    @(posedge CLK); @(posedge CLK); #1;
    nRST = 1'b1;
  endtask

  initial begin
    logic acc;
    #1;
    do_reset();
    // Scenario 1: single instruction with register selects 1 and 2
    send(32'h8C22_0004, 32'h0000_0040, 1'b1);
    idle(1'b1, 2);
    // Scenario 2: fill while decode stalls, 0x33 held until space frees
    send(32'h11, 32'h100, 1'b0);
    send(32'h22, 32'h104, 1'b0);
    cyc(1'b1, 32'h33, 32'h108, 1'b0, 1'b0, acc);
    cyc(1'b1, 32'h33, 32'h108, 1'b0, 1'b0, acc);
    send(32'h33, 32'h108, 1'b1);
    idle(1'b1, 3);
    // Scenario 3: simultaneous push and pop at count 1
    send(32'hA1, 32'h200, 1'b0);
    send(32'hA2, 32'h204, 1'b1);
    idle(1'b1, 2);
    // Scenario 4: flush while full drops the same-cycle push
    send(32'h1, 32'h300, 1'b0);
    send(32'h2, 32'h304, 1'b0);
    cyc(1'b1, 32'h44, 32'h308, 1'b0, 1'b1, acc);
    idle(1'b1, 2);
    // Scenario 5: reset mid-stream, then 0x55 is the first output
    send(32'h3, 32'h400, 1'b0);
    send(32'h4, 32'h404, 1'b0);
    #2;
    do_reset();
    send(32'h55, 32'h500, 1'b1);
    idle(1'b1, 2);
    // Scenario 6: five stalled cycles then one flush
    send(32'h5, 32'h600, 1'b0);
    send(32'h6, 32'h604, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'h66, 32'h608, 1'b0, 1'b0, acc);
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, acc);
    idle(1'b1, 2);
`ifdef IFID_PERF_EN
    chk("perf_stall_5", 64'(stall_cnt), 64'd5);
    chk("perf_flush_1", 64'(flush_cnt), 64'd1);
`endif
    // Randomized traffic with occasional flushes and resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        cyc(1'($urandom_range(0, 3) != 0), $urandom(), $urandom(),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0), acc);
      end
    end
    idle(1'b1, 4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
